// File: rtl/aes_block_packer.sv
// Packs four 32-bit stream words into one 128-bit AES block, word 0 least significant.
// Define AES_PACKER_BSWAP_EN to byte-reverse each word before it is stored.
module aes_block_packer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic [31:0]      in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [127:0]     out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [CNT_W-1:0] blk_cnt_o,
   output logic             busy_o
);

   typedef enum logic {StFill, StFull} state_e;

   state_e           state_q;
   logic [1:0]       idx_q;
   logic [127:0]     data_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      word;
   logic             in_hs;
   logic             out_hs;

`ifdef AES_PACKER_BSWAP_EN
   assign word = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
   assign word = in_data_i;
`endif

   // A full block can be refilled in the same cycle it is taken.
   assign in_ready_o  = !clear_i && ((state_q == StFill) || out_ready_i);
   assign out_valid_o = !clear_i && (state_q == StFull);
   assign in_hs       = in_valid_i && in_ready_o;
   assign out_hs      = out_valid_o && out_ready_i;

   assign out_data_o = data_q;
   assign blk_cnt_o  = cnt_q;
   assign busy_o     = (idx_q != 2'd0) || (state_q == StFull);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StFill;
         idx_q   <= 2'd0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else if (clear_i) begin
         state_q <= StFill;
         idx_q   <= 2'd0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         if (out_hs) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         case (state_q)
            StFill: begin
               if (in_hs) begin
                  data_q[{idx_q, 5'b0} +: 32] <= word;
                  idx_q                       <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     state_q <= StFull;
                  end
               end
            end
            StFull: begin
               if (out_hs) begin
                  state_q <= StFill;
                  // in_ready_o tracks out_ready_i here, so an input handshake implies out_hs.
                  if (in_hs) begin
                     data_q[31:0] <= word;
                     idx_q        <= 2'd1;
                  end
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

endmodule

// File: doc/aes_block_packer.md
AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the emitted-block counter.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clear_i  input  1  synchronous clear from the controller (clear_o of the peripheral slave).
REQ-005 SHALL have port in_data_i  input  32  stream word from the HWPE source streamer.
REQ-006 SHALL have port in_valid_i  input  1  stream word valid.
REQ-007 SHALL have port in_ready_o  output  1  stream word accepted when high with in_valid_i.
REQ-008 SHALL have port out_data_o  output  128  assembled AES block to the engine.
REQ-009 SHALL have port out_valid_o  output  1  block valid.
REQ-010 SHALL have port out_ready_i  input  1  engine accepts block.
REQ-011 SHALL have port blk_cnt_o  output  CNT_W  blocks delivered since reset/clear.
REQ-012 SHALL have port busy_o  output  1  partial or full block held.

Function
REQ-013 SHALL implement two states: FILL (collecting words) and FULL (block presented).
REQ-014 SHALL keep a 2-bit word index, 0..3, advanced on every input handshake (in_valid_i and in_ready_o).
REQ-015 SHALL write word k to out_data_o[32k+31:32k]; word 0 is least significant.
REQ-016 SHALL drive in_ready_o = 1 in FILL; in FULL, in_ready_o = out_ready_i (same-cycle refill).
REQ-017 SHALL go FILL->FULL on the handshake at index 3; out_valid_o rises the next cycle (1-cycle latency).
REQ-018 SHALL go FULL->FILL on an output handshake with no input handshake in the same cycle.
REQ-019 On simultaneous output and input handshake in FULL, SHALL store the new word as word 0, index->1, and enter FILL.
REQ-020 SHALL hold out_data_o and out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-021 SHALL increment blk_cnt_o by 1 per output handshake, wrapping from 2^CNT_W-1 to 0.
REQ-022 SHALL drive busy_o = 1 when the index is non-zero or the state is FULL.
REQ-023 SHALL not change the index while in_valid_i=0; gaps in the stream are allowed.
REQ-024 When clear_i=1, SHALL on the next edge enter FILL, zero the index, the block register and blk_cnt_o, drop any partial/full block, and ignore any simultaneous handshake; clear has priority.
REQ-025 During clear_i=1, in_ready_o and out_valid_o SHALL be 0.

Reset
REQ-026 On rst_ni=0, SHALL immediately enter FILL with index 0 and drive out_data_o=0, out_valid_o=0, blk_cnt_o=0, busy_o=0; in_ready_o=1 once rst_ni=1.
REQ-027 Reset mid-block SHALL discard the partial block; no block is emitted from pre-reset words.

Configuration
REQ-028 With macro AES_PACKER_BSWAP_EN defined, SHALL byte-reverse each input word before storing it (in_data_i[7:0] to bits [31:24] of the slot, etc.).
REQ-029 Without AES_PACKER_BSWAP_EN, SHALL store each word unmodified.

Verification
REQ-030 Words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on back-to-back cycles, out_ready_i=1 -> out_valid_o one cycle after the 4th word, out_data_o=0x0F0E0D0C_0B0A0908_07060504_03020100, blk_cnt_o=1.
REQ-031 Same words with out_ready_i=0 for 5 cycles -> out_data_o stable, in_ready_o=0, blk_cnt_o=0 until out_ready_i=1, then 1.
REQ-032 Continuous stream of 8 words, out_ready_i=1 -> two blocks, 8 input handshakes in 8 consecutive cycles, blk_cnt_o=2.
REQ-033 Two words accepted, then clear_i=1 -> busy_o=0, no block emitted; the next 4 words form one block equal to those 4 words.
REQ-034 blk_cnt_o preset near wrap (CNT_W=2, 4 blocks delivered) -> blk_cnt_o sequence 1,2,3,0.
REQ-035 With AES_PACKER_BSWAP_EN, input word 0x00112233 in slot 0 -> out_data_o[31:0]=0x33221100.
